exception_commit: RTL and testbench
===================================

EXCEPTION_COMMIT -- requirements
Module: exception_commit

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, general exception entry PC.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have commit_en  in  1  pipeline not stalled, slot inputs may commit.
REQ-004 SHALL have per slot s in {0,1}: s_valid  in  1; s_pc  in  32; s_bd  in  1  in delay slot; s_exc  in  exc_vec_t  flags {adel_if, ri, ov, trap, sys, bp, adel, ades, eret}; s_badvaddr  in  32  data fault address.
REQ-005 SHALL have int_pending  in  1  masked interrupt request, already qualified by IE and IM.
REQ-006 SHALL have epc_we  in  1; epc_wdata  in  32  MTC0 write to EPC.
REQ-007 SHALL have flush  out  1; redirect_valid  out  1; redirect_pc  out  32; redirect_ack  in  1  fetch accepted redirect.
REQ-008 SHALL have epc_o  out  32; exccode_o  out  5; bd_o  out  1; badvaddr_o  out  32; exl_o  out  1.

Function
REQ-009 SHALL implement states IDLE, REDIRECT; only IDLE evaluates inputs.
REQ-010 In IDLE with commit_en=1, slot 0 is older; a slot excepts when valid and any exc bit set, or for slot 0 only, when int_pending=1 and exl_o=0.
REQ-011 Per-slot priority SHALL be Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Tr(13) > Sys(8) > Bp(9) > AdEL-data(4) > AdES(5) > ERET; the code in parentheses is the ExcCode.
REQ-012 If slot 0 excepts, slot 1 SHALL be ignored entirely; otherwise slot 1 is evaluated.
REQ-013 On a non-ERET exception, if exl_o=0: epc_o <= s_bd ? s_pc-4 : s_pc, bd_o <= s_bd; if exl_o=1, epc_o and bd_o SHALL be unchanged.
REQ-014 On a non-ERET exception: exccode_o <= the code; exl_o <= 1; for AdEL-fetch, badvaddr_o <= s_pc; for AdEL/AdES-data, badvaddr_o <= s_badvaddr; otherwise badvaddr_o is unchanged.
REQ-015 On ERET: exl_o <= 0; redirect_pc <= epc_o (the pre-update value); no other field changes.
REQ-016 On any exception or ERET: redirect_pc <= EXC_VECTOR (non-ERET) and flush <= 1 for exactly one cycle; redirect_valid <= 1; next state REDIRECT; latency is 1 cycle from the committing edge.
REQ-017 In REDIRECT, redirect_valid and redirect_pc SHALL hold until a cycle with redirect_ack=1; redirect_valid drops on the next edge and the state returns to IDLE.
REQ-018 In REDIRECT, all slot inputs and int_pending SHALL be ignored; flush stays 0 after its first cycle.
REQ-019 epc_we=1 SHALL write epc_o <= epc_wdata when no exception commits that cycle; a simultaneous committing exception that updates EPC wins.
REQ-020 commit_en=0 in IDLE SHALL cause no state or output change except epc_we.
REQ-021 redirect_ack in IDLE SHALL be ignored.

Reset
REQ-022 On rst=1 at a clk edge: state IDLE; flush=0; redirect_valid=0; redirect_pc=0; epc_o=0; exccode_o=0; bd_o=0; badvaddr_o=0; exl_o=1 (boot in exception level).
REQ-023 Reset during REDIRECT SHALL abandon the redirect without needing ack.

Structure
REQ-024 exc_vec_t, the ExcCode constants and the state enum SHALL live in the shared package alongside the existing TT_* trap-type defines.
REQ-025 One sub-module exc_prio (combinational, one per slot: exc_vec_t + int -> hit, exccode, is_eret, is_fetch_fault) SHALL be instantiated twice.

Verification
REQ-026 Bench SHALL cover slot0 trap=1, pc=0x8000_0100, bd=0, exl=0 -> next cycle: flush=1, epc=0x8000_0100, exccode=13, redirect_pc=0xBFC0_0380, exl=1.
REQ-027 Bench SHALL cover slot0 clean, slot1 ov=1, pc=0x8000_0204, bd=1 -> epc=0x8000_0200, bd=1, exccode=12.
REQ-028 Bench SHALL cover slot0 ades, badvaddr=0x1003 plus slot1 sys -> exccode=5, badvaddr=0x1003, slot1 ignored.
REQ-029 Bench SHALL cover ERET with epc=0x8000_0040 and redirect_ack delayed 3 cycles -> redirect_pc=0x8000_0040 held 4 cycles, exl=0, and an exception during the wait is ignored.
REQ-030 Bench SHALL cover epc_we=1 (0x1234) with slot0 ri same cycle, exl=0 -> epc = slot0 pc, not 0x1234; with exl=1 -> epc=0x1234.
REQ-031 Bench SHALL cover int_pending=1 with exl=1 -> no action; reset asserted mid-REDIRECT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/exception_commit_pkg.sv
// ============================================================================
//  Module      : exception_commit_pkg
//  Description : Shared exception types, ExcCodes and commit FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exception_commit_pkg;

    // Trap-type tags shared with the rest of the pipeline.
    localparam logic [1:0] TT_NONE = 2'd0;
    localparam logic [1:0] TT_EXC  = 2'd1;
    localparam logic [1:0] TT_INT  = 2'd2;
    localparam logic [1:0] TT_ERET = 2'd3;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic trap;
        logic sys;
        logic bp;
        logic adel;
        logic ades;
        logic eret;
    } exc_vec_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/exception_commit_prio.sv
// ============================================================================
//  Module      : exc_prio
//  Description : Per-slot exception priority encoder (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_prio
    import exception_commit_pkg::*;
(
    input  exc_vec_t   exc_i,
    input  logic       int_i,
    output logic       hit_o,
    output logic [4:0] exccode_o,
    output logic       is_eret_o,
    output logic       is_fetch_fault_o
);

    always_comb begin
        hit_o            = 1'b1;
        exccode_o        = EXC_INT;
        is_eret_o        = 1'b0;
        is_fetch_fault_o = 1'b0;
        if (int_i) begin
            exccode_o = EXC_INT;
        end else if (exc_i.adel_if) begin
            exccode_o        = EXC_ADEL;
            is_fetch_fault_o = 1'b1;
        end else if (exc_i.ri) begin
            exccode_o = EXC_RI;
        end else if (exc_i.ov) begin
            exccode_o = EXC_OV;
        end else if (exc_i.trap) begin
            exccode_o = EXC_TR;
        end else if (exc_i.sys) begin
            exccode_o = EXC_SYS;
        end else if (exc_i.bp) begin
            exccode_o = EXC_BP;
        end else if (exc_i.adel) begin
            exccode_o = EXC_ADEL;
        end else if (exc_i.ades) begin
            exccode_o = EXC_ADES;
        end else if (exc_i.eret) begin
            is_eret_o = 1'b1;
        end else begin
            hit_o = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exception_commit.sv
// ============================================================================
//  Module      : exception_commit
//  Description : Two-slot precise exception/ERET commit with fetch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exception_commit
    import exception_commit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_en,
    input  logic        s0_valid,
    input  logic [31:0] s0_pc,
    input  logic        s0_bd,
    input  exc_vec_t    s0_exc,
    input  logic [31:0] s0_badvaddr,
    input  logic        s1_valid,
    input  logic [31:0] s1_pc,
    input  logic        s1_bd,
    input  exc_vec_t    s1_exc,
    input  logic [31:0] s1_badvaddr,
    input  logic        int_pending,
    input  logic        epc_we,
    input  logic [31:0] epc_wdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic [31:0] epc_o,
    output logic [4:0]  exccode_o,
    output logic        bd_o,
    output logic [31:0] badvaddr_o,
    output logic        exl_o
);

    state_e      state_q, state_d;
    logic        flush_q, flush_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        bd_q, bd_d;
    logic [31:0] bva_q, bva_d;
    logic        exl_q, exl_d;

    exc_vec_t    w_exc   [2];
    logic        w_int   [2];
    logic        w_hit   [2];
    logic [4:0]  w_code  [2];
    logic        w_eret  [2];
    logic        w_fetch [2];
    logic [31:0] w_pc    [2];
    logic        w_bd    [2];
    logic [31:0] w_bva   [2];

    // Only slot 0 (the older instruction) can take the interrupt.
    assign w_exc[0] = s0_valid ? s0_exc : '0;
    assign w_exc[1] = s1_valid ? s1_exc : '0;
    assign w_int[0] = int_pending & ~exl_q;
    assign w_int[1] = 1'b0;
    assign w_pc[0]  = s0_pc;
    assign w_pc[1]  = s1_pc;
    assign w_bd[0]  = s0_bd;
    assign w_bd[1]  = s1_bd;
    assign w_bva[0] = s0_badvaddr;
    assign w_bva[1] = s1_badvaddr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            exc_prio u_prio (
                .exc_i            (w_exc[gi]),
                .int_i            (w_int[gi]),
                .hit_o            (w_hit[gi]),
                .exccode_o        (w_code[gi]),
                .is_eret_o        (w_eret[gi]),
                .is_fetch_fault_o (w_fetch[gi])
            );
        end
    endgenerate

    logic        w_sel;
    logic        w_data_fault;

    assign w_sel        = ~w_hit[0];
    assign w_data_fault = ~w_eret[w_sel] & ~w_fetch[w_sel] & ~w_int[w_sel]
                        & ((w_code[w_sel] == EXC_ADEL) | (w_code[w_sel] == EXC_ADES));

    always_comb begin
        state_d   = state_q;
        flush_d   = 1'b0;
        rvalid_d  = rvalid_q;
        rpc_d     = rpc_q;
        epc_d     = epc_we ? epc_wdata : epc_q;
        exccode_d = exccode_q;
        bd_d      = bd_q;
        bva_d     = bva_q;
        exl_d     = exl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (commit_en && (w_hit[0] || w_hit[1])) begin
                    state_d  = ST_REDIRECT;
                    flush_d  = 1'b1;
                    rvalid_d = 1'b1;
                    if (w_eret[w_sel]) begin
                        exl_d = 1'b0;
                        rpc_d = epc_q;
                    end else begin
                        rpc_d     = EXC_VECTOR;
                        exccode_d = w_code[w_sel];
                        exl_d     = 1'b1;
                        // A nested exception keeps the original return point.
                        if (!exl_q) begin
                            epc_d = w_bd[w_sel] ? (w_pc[w_sel] - 32'd4) : w_pc[w_sel];
                            bd_d  = w_bd[w_sel];
                        end
                        if (w_fetch[w_sel]) begin
                            bva_d = w_pc[w_sel];
                        end else if (w_data_fault) begin
                            bva_d = w_bva[w_sel];
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                if (redirect_ack) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flush_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rpc_q     <= 32'd0;
            epc_q     <= 32'd0;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            bva_q     <= 32'd0;
            exl_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            rvalid_q  <= rvalid_d;
            rpc_q     <= rpc_d;
            epc_q     <= epc_d;
            exccode_q <= exccode_d;
            bd_q      <= bd_d;
            bva_q     <= bva_d;
            exl_q     <= exl_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = rvalid_q;
    assign redirect_pc    = rpc_q;
    assign epc_o          = epc_q;
    assign exccode_o      = exccode_q;
    assign bd_o           = bd_q;
    assign badvaddr_o     = bva_q;
    assign exl_o          = exl_q;

endmodule

`default_nettype wire

// File: tb/tb_exception_commit.sv
// ============================================================================
//  Module      : tb_exception_commit
//  Description : Scoreboard bench for exception_commit directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exception_commit;
    import exception_commit_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst, commit_en, int_pending, epc_we, redirect_ack;
    logic        s0_valid, s0_bd, s1_valid, s1_bd;
    logic [31:0] s0_pc, s0_badvaddr, s1_pc, s1_badvaddr, epc_wdata;
    exc_vec_t    s0_exc, s1_exc;
    logic        flush, redirect_valid, bd_o, exl_o;
    logic [31:0] redirect_pc, epc_o, badvaddr_o;
    logic [4:0]  exccode_o;

    always #5 clk = ~clk;

    exception_commit #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst), .commit_en(commit_en),
        .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_bd(s0_bd), .s0_exc(s0_exc),
        .s0_badvaddr(s0_badvaddr),
        .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_bd(s1_bd), .s1_exc(s1_exc),
        .s1_badvaddr(s1_badvaddr),
        .int_pending(int_pending), .epc_we(epc_we), .epc_wdata(epc_wdata),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ack(redirect_ack), .epc_o(epc_o), .exccode_o(exccode_o),
        .bd_o(bd_o), .badvaddr_o(badvaddr_o), .exl_o(exl_o)
    );

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] bva;
        logic        exl;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every flush pulse is one redirect event to score.
    always @(negedge clk) begin
        if (flush === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flush actual=1 expected=0 rpc=%h", redirect_pc);
            end else begin
                e = q.pop_front();
                chk("ev_rvalid",   {31'd0, redirect_valid}, 32'd1);
                chk("ev_rpc",      redirect_pc, e.rpc);
                chk("ev_epc",      epc_o, e.epc);
                chk("ev_exccode",  {27'd0, exccode_o}, {27'd0, e.code});
                chk("ev_bd",       {31'd0, bd_o}, {31'd0, e.bd});
                chk("ev_badvaddr", badvaddr_o, e.bva);
                chk("ev_exl",      {31'd0, exl_o}, {31'd0, e.exl});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_en = 1'b1; int_pending = 1'b0; epc_we = 1'b0; epc_wdata = '0;
        s0_valid = 1'b0; s0_pc = '0; s0_bd = 1'b0; s0_exc = '0; s0_badvaddr = '0;
        s1_valid = 1'b0; s1_pc = '0; s1_bd = 1'b0; s1_exc = '0; s1_badvaddr = '0;
    endtask

    task automatic expect_ev(logic [31:0] rpc, logic [31:0] epc, logic [4:0] code,
                             logic bd, logic [31:0] bva, logic exl);
        exp_t x;
        x.rpc = rpc; x.epc = epc; x.code = code; x.bd = bd; x.bva = bva; x.exl = exl;
        q.push_back(x);
    endtask

    task automatic commit_and_ack();
        step();
        idle_inputs();
        redirect_ack = 1'b1;
        step();
        redirect_ack = 1'b0;
        chk("ack_drop_rvalid", {31'd0, redirect_valid}, 32'd0);
    endtask

    task automatic do_eret(logic [31:0] rpc, logic [31:0] epc, logic [4:0] code,
                           logic bd, logic [31:0] bva);
        s0_valid = 1'b1; s0_pc = 32'h8000_0F00; s0_exc.eret = 1'b1;
        expect_ev(rpc, epc, code, bd, bva, 1'b0);
        commit_and_ack();
    endtask

    task automatic chk_reset_values();
        chk("rst_flush",    {31'd0, flush}, 32'd0);
        chk("rst_rvalid",   {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc",      redirect_pc, 32'd0);
        chk("rst_epc",      epc_o, 32'd0);
        chk("rst_exccode",  {27'd0, exccode_o}, 32'd0);
        chk("rst_bd",       {31'd0, bd_o}, 32'd0);
        chk("rst_badvaddr", badvaddr_o, 32'd0);
        chk("rst_exl",      {31'd0, exl_o}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; redirect_ack = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst = 1'b0;
        chk_reset_values();

        // MTC0 EPC, then ERET with a slow ack; exceptions during the wait are ignored.
        commit_en = 1'b0; epc_we = 1'b1; epc_wdata = 32'h8000_0040;
        step();
        idle_inputs();
        chk("mtc0_epc", epc_o, 32'h8000_0040);
        s0_valid = 1'b1; s0_pc = 32'h8000_0010; s0_exc.eret = 1'b1;
        expect_ev(32'h8000_0040, 32'h8000_0040, 5'd0, 1'b0, 32'd0, 1'b0);
        step();
        s0_exc = '0; s0_exc.trap = 1'b1; int_pending = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("wait_rvalid", {31'd0, redirect_valid}, 32'd1);
            chk("wait_rpc", redirect_pc, 32'h8000_0040);
            if (i == 4) begin
                idle_inputs();
                redirect_ack = 1'b1;
            end
            step();
        end
        redirect_ack = 1'b0;
        chk("eret_done_rvalid", {31'd0, redirect_valid}, 32'd0);
        chk("eret_done_exl", {31'd0, exl_o}, 32'd0);
        chk("eret_done_exccode", {27'd0, exccode_o}, 32'd0);

        // Slot 0 trap, not in delay slot.
        s0_valid = 1'b1; s0_pc = 32'h8000_0100; s0_exc.trap = 1'b1;
        expect_ev(VEC, 32'h8000_0100, 5'd13, 1'b0, 32'd0, 1'b1);
        commit_and_ack();
        do_eret(32'h8000_0100, 32'h8000_0100, 5'd13, 1'b0, 32'd0);

        // Slot 1 overflow in a delay slot.
        s0_valid = 1'b1; s0_pc = 32'h8000_0200;
        s1_valid = 1'b1; s1_pc = 32'h8000_0204; s1_bd = 1'b1; s1_exc.ov = 1'b1;
        expect_ev(VEC, 32'h8000_0200, 5'd12, 1'b1, 32'd0, 1'b1);
        commit_and_ack();
        do_eret(32'h8000_0200, 32'h8000_0200, 5'd12, 1'b1, 32'd0);

        // Slot 0 store fault masks slot 1 syscall.
        s0_valid = 1'b1; s0_pc = 32'h8000_0300; s0_exc.ades = 1'b1; s0_badvaddr = 32'h1003;
        s1_valid = 1'b1; s1_pc = 32'h8000_0304; s1_bd = 1'b1; s1_exc.sys = 1'b1;
        s1_badvaddr = 32'hDEAD;
        expect_ev(VEC, 32'h8000_0300, 5'd5, 1'b0, 32'h1003, 1'b1);
        commit_and_ack();

        // EPC write with exception while EXL=1: the write lands.
        epc_we = 1'b1; epc_wdata = 32'h1234;
        s0_valid = 1'b1; s0_pc = 32'h8000_0400; s0_exc.ri = 1'b1;
        expect_ev(VEC, 32'h1234, 5'd10, 1'b0, 32'h1003, 1'b1);
        commit_and_ack();
        do_eret(32'h1234, 32'h1234, 5'd10, 1'b0, 32'h1003);

        // EPC write with exception while EXL=0: the exception wins.
        epc_we = 1'b1; epc_wdata = 32'h1234;
        s0_valid = 1'b1; s0_pc = 32'h8000_0500; s0_exc.ri = 1'b1;
        expect_ev(VEC, 32'h8000_0500, 5'd10, 1'b0, 32'h1003, 1'b1);
        commit_and_ack();

        // Interrupt masked by EXL=1.
        int_pending = 1'b1;
        step();
        idle_inputs();
        chk("int_exl_rvalid", {31'd0, redirect_valid}, 32'd0);
        chk("int_exl_exccode", {27'd0, exccode_o}, 32'd10);
        do_eret(32'h8000_0500, 32'h8000_0500, 5'd10, 1'b0, 32'h1003);

        // Interrupt outranks a fetch fault on slot 0.
        int_pending = 1'b1;
        s0_valid = 1'b1; s0_pc = 32'h8000_0600; s0_exc.adel_if = 1'b1;
        expect_ev(VEC, 32'h8000_0600, 5'd0, 1'b0, 32'h1003, 1'b1);
        commit_and_ack();

        // Nested fetch fault on slot 1: EPC/BD kept, BadVAddr = PC.
        int_pending = 1'b1;
        s0_valid = 1'b1; s0_pc = 32'h8000_0700;
        s1_valid = 1'b1; s1_pc = 32'h8000_0704; s1_bd = 1'b1; s1_exc.adel_if = 1'b1;
        expect_ev(VEC, 32'h8000_0600, 5'd4, 1'b0, 32'h8000_0704, 1'b1);
        commit_and_ack();

        // Stalled pipeline commits nothing.
        commit_en = 1'b0; s0_valid = 1'b1; s0_pc = 32'h8000_0780; s0_exc.trap = 1'b1;
        step();
        idle_inputs();
        chk("stall_rvalid", {31'd0, redirect_valid}, 32'd0);
        chk("stall_exccode", {27'd0, exccode_o}, 32'd4);

        // Reset in the middle of a redirect.
        s0_valid = 1'b1; s0_pc = 32'h8000_0800; s0_exc.bp = 1'b1;
        expect_ev(VEC, 32'h8000_0600, 5'd9, 1'b0, 32'h8000_0704, 1'b1);
        step();
        idle_inputs();
        chk("pre_rst_rvalid", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_values();
        step();
        chk("post_rst_rvalid", {31'd0, redirect_valid}, 32'd0);

        repeat (2) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_flush actual=%0d pending expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
